// File: rtl/me_move_sched_pkg.sv
// me_move_sched_pkg: shared direction codes, key bit positions, FSM states and defaults for the move scheduler.
package me_move_sched_pkg;
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int KEY_UP_BIT    = 0;
    localparam int KEY_DOWN_BIT  = 1;
    localparam int KEY_LEFT_BIT  = 2;
    localparam int KEY_RIGHT_BIT = 3;

    localparam int TICK_DIV_DEF    = 4;
    localparam int ACCEL_STEPS_DEF = 8;
endpackage

// File: rtl/rr_arb4.sv
// rr_arb4: pure 4-way round-robin arbiter; the search starts at the entry after last_grant_i.
//   req_i[3:0]        request per direction (index = direction code)
//   last_grant_i[1:0] most recently granted direction
//   gnt_o[1:0]        granted direction (last_grant_i when nothing requested)
//   gnt_valid_o       at least one request present
module rr_arb4 (
    input  logic [3:0] req_i,
    input  logic [1:0] last_grant_i,
    output logic [1:0] gnt_o,
    output logic       gnt_valid_o
);
    logic [1:0] idx;

    // Walk from the farthest candidate to the nearest so the nearest requester wins.
    always_comb begin
        gnt_o       = last_grant_i;
        gnt_valid_o = 1'b0;
        idx         = last_grant_i;
        for (int k = 4; k >= 1; k--) begin
            idx = last_grant_i + 2'(k);
            if (req_i[idx]) begin
                gnt_o       = idx;
                gnt_valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/me_move_sched.sv
// me_move_sched: turns held direction keys into a rate-limited stream of single-direction move strobes.
//   clk_run      game logic clock
//   rst_n        asynchronous active-low reset
//   en_i         game running; low forces IDLE
//   pause_i      game paused; high forces IDLE
//   key_i[3:0]   synchronised keys [0]=up [1]=down [2]=left [3]=right
//   move_en_o    one-cycle move strobe
//   direct_o     direction of the last issued move
//   moving_o     scheduler is in RUN
//   accel_o      acceleration active
// Optional feature macro: MOVE_ACCEL_EN (halves the move period after ACCEL_STEPS periodic moves).
module me_move_sched
    import me_move_sched_pkg::*;
#(
    parameter int TICK_DIV    = TICK_DIV_DEF,
    parameter int ACCEL_STEPS = ACCEL_STEPS_DEF
) (
    input  logic       clk_run,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       pause_i,
    input  logic [3:0] key_i,
    output logic       move_en_o,
    output logic [1:0] direct_o,
    output logic       moving_o,
    output logic       accel_o
);
    localparam logic [7:0] PER_SLOW = 8'(TICK_DIV);

    state_e     state_q;
    logic [7:0] cnt_q;
    logic [1:0] ptr_q;
    logic [1:0] dir_q;
    logic       move_en_q;
    logic [3:0] mask;
    logic [1:0] gnt;
    logic       gnt_v;
    logic [7:0] period;
    logic       issue;

    // Opposing keys cancel each other; a stopped or paused game requests nothing.
    always_comb begin
        mask = key_i;
        if (key_i[KEY_UP_BIT] && key_i[KEY_DOWN_BIT]) begin
            mask[KEY_UP_BIT]   = 1'b0;
            mask[KEY_DOWN_BIT] = 1'b0;
        end
        if (key_i[KEY_LEFT_BIT] && key_i[KEY_RIGHT_BIT]) begin
            mask[KEY_LEFT_BIT]  = 1'b0;
            mask[KEY_RIGHT_BIT] = 1'b0;
        end
        if (!en_i || pause_i) mask = 4'b0000;
    end

    rr_arb4 u_arb (
        .req_i        (mask),
        .last_grant_i (ptr_q),
        .gnt_o        (gnt),
        .gnt_valid_o  (gnt_v)
    );

`ifdef MOVE_ACCEL_EN
    localparam logic [7:0] PER_FAST = (TICK_DIV > 1) ? 8'(TICK_DIV >> 1) : 8'd1;
    logic [7:0] run_cnt_q;
    logic [7:0] run_cnt_d;
    logic       accel_q;
    logic       accel_d;
    // The first move out of IDLE is not counted; only periodic moves advance run_cnt.
    assign run_cnt_d = (state_q == RUN && run_cnt_q != 8'hFF) ? run_cnt_q + 8'd1 : run_cnt_q;
    assign accel_d   = int'(run_cnt_d) >= ACCEL_STEPS;
    assign period    = accel_q ? PER_FAST : PER_SLOW;
    assign accel_o   = accel_q;
`else
    logic unused_accel_steps;
    assign unused_accel_steps = ^ACCEL_STEPS;
    assign period  = PER_SLOW;
    assign accel_o = 1'b0;
`endif

    // ">=" lets a shortened period take effect on a count already past its new limit.
    assign issue = (state_q == IDLE) || (cnt_q >= period - 8'd1);

    always_ff @(posedge clk_run or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            ptr_q     <= DIR_RIGHT;
            dir_q     <= DIR_UP;
            move_en_q <= 1'b0;
`ifdef MOVE_ACCEL_EN
            run_cnt_q <= 8'd0;
            accel_q   <= 1'b0;
`endif
        end else if (!gnt_v) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            move_en_q <= 1'b0;
`ifdef MOVE_ACCEL_EN
            run_cnt_q <= 8'd0;
            accel_q   <= 1'b0;
`endif
        end else if (issue) begin
            state_q   <= RUN;
            cnt_q     <= 8'd0;
            dir_q     <= gnt;
            ptr_q     <= gnt;
            move_en_q <= 1'b1;
`ifdef MOVE_ACCEL_EN
            run_cnt_q <= run_cnt_d;
            accel_q   <= accel_d;
`endif
        end else begin
            cnt_q     <= cnt_q + 8'd1;
            move_en_q <= 1'b0;
        end
    end

    assign move_en_o = move_en_q;
    assign direct_o  = dir_q;
    assign moving_o  = (state_q == RUN);
endmodule

// File: tb/tb_me_move_sched.sv
// tb_me_move_sched: directed self-checking bench for me_move_sched (TICK_DIV=4, ACCEL_STEPS=8).
module tb_me_move_sched;
    logic       clk_run = 1'b0;
    logic       rst_n   = 1'b0;
    logic       en_i    = 1'b1;
    logic       pause_i = 1'b0;
    logic [3:0] key_i   = 4'b0000;
    logic       move_en_o;
    logic [1:0] direct_o;
    logic       moving_o;
    logic       accel_o;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3;
`ifdef MOVE_ACCEL_EN
    localparam int ACC_ON = 1, FAST_GAP = 2;
`else
    localparam int ACC_ON = 0, FAST_GAP = 4;
`endif

    me_move_sched #(.TICK_DIV(4), .ACCEL_STEPS(8)) dut (
        .clk_run   (clk_run),
        .rst_n     (rst_n),
        .en_i      (en_i),
        .pause_i   (pause_i),
        .key_i     (key_i),
        .move_en_o (move_en_o),
        .direct_o  (direct_o),
        .moving_o  (moving_o),
        .accel_o   (accel_o)
    );

    always #5 clk_run = ~clk_run;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Waits for the next strobe (bounded) and checks its distance in cycles and its direction.
    task automatic expect_strobe(input string tag, input int gap, input logic [1:0] d);
        int seen = 0;
        for (int i = 1; i <= gap + 6 && seen == 0; i++) begin
            @(negedge clk_run);
            if (move_en_o) seen = i;
        end
        chk({tag, "_gap"}, seen, gap);
        chk({tag, "_dir"}, int'(direct_o), int'(d));
    endtask

    initial begin
        int quiet;
        #1;
        chk("rst_move_en", int'(move_en_o), 0);
        chk("rst_dir", int'(direct_o), int'(UP));
        chk("rst_moving", int'(moving_o), 0);
        chk("rst_accel", int'(accel_o), 0);
        @(negedge clk_run);
        rst_n = 1'b1;
        @(negedge clk_run);
        chk("idle_moving", int'(moving_o), 0);

        key_i = 4'b0001;
        expect_strobe("up_first", 1, UP);
        chk("up_moving", int'(moving_o), 1);
        for (int i = 0; i < 3; i++) expect_strobe("up_hold", 4, UP);

        key_i = 4'b1001;
        expect_strobe("diag1", 4, RIGHT);
        expect_strobe("diag2", 4, UP);
        expect_strobe("diag3", 4, RIGHT);
        expect_strobe("diag4", 4, UP);

        key_i = 4'b0011;
        @(negedge clk_run);
        chk("ud_moving", int'(moving_o), 0);
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_run);
            if (move_en_o) quiet++;
        end
        chk("ud_quiet", quiet, 0);
        chk("ud_still_idle", int'(moving_o), 0);
        key_i = 4'b0111;
        expect_strobe("ud_left", 1, LEFT);
        expect_strobe("ud_left_hold", 4, LEFT);

        @(negedge clk_run);
        pause_i = 1'b1;
        @(negedge clk_run);
        chk("pause_moving", int'(moving_o), 0);
        chk("pause_move_en", int'(move_en_o), 0);
        pause_i = 1'b0;
        expect_strobe("pause_resume", 1, LEFT);
        expect_strobe("pause_restart", 4, LEFT);

        key_i = 4'b0001;
        expect_strobe("pre_rst_up", 4, UP);
        key_i = 4'b1001;
        @(negedge clk_run);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_moving", int'(moving_o), 0);
        chk("arst_dir", int'(direct_o), int'(UP));
        chk("arst_move_en", int'(move_en_o), 0);
        chk("arst_accel", int'(accel_o), 0);
        @(negedge clk_run);
        rst_n = 1'b1;
        expect_strobe("post_rst", 1, UP);
        expect_strobe("post_rst_next", 4, RIGHT);

        @(negedge clk_run);
        en_i = 1'b0;
        @(negedge clk_run);
        chk("en_low_moving", int'(moving_o), 0);
        en_i = 1'b1;
        expect_strobe("en_resume", 1, UP);

        key_i = 4'b0000;
        @(negedge clk_run);
        @(negedge clk_run);
        chk("acc_pre_idle", int'(moving_o), 0);
        key_i = 4'b0100;
        expect_strobe("acc_first", 1, LEFT);
        for (int i = 0; i < 7; i++) expect_strobe("acc_slow", 4, LEFT);
        chk("acc_off_before", int'(accel_o), 0);
        expect_strobe("acc_slow8", 4, LEFT);
        chk("acc_engaged", int'(accel_o), ACC_ON);
        expect_strobe("acc_fast1", FAST_GAP, LEFT);
        expect_strobe("acc_fast2", FAST_GAP, LEFT);
        key_i = 4'b0000;
        @(negedge clk_run);
        chk("acc_release", int'(accel_o), 0);
        chk("acc_release_moving", int'(moving_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
